wb_burst_master: RTL and testbench

WB_BURST_MASTER -- requirements
Module: wb_burst_master

---
 rtl/wb_master_pkg.sv | 6 +
 rtl/wb_beat_timer.sv | 19 +
 rtl/wb_burst_master.sv | 118 +++++++++++
 tb/tb_wb_burst_master.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_master_pkg.sv
// wb_master_pkg: shared state encoding and constants for the Wishbone burst master.
package wb_master_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_WDAT, ST_REQ, ST_GAP} state_t;
    localparam logic [31:0] ADR_INC = 32'd4;
    localparam int TIMEOUT_CYC_DEF = 1024;
endpackage

// File: rtl/wb_beat_timer.sv
// wb_beat_timer: per-beat cycle counter, expires on the TIMEOUT_CYC-th enabled cycle.
module wb_beat_timer import wb_master_pkg::*; #(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] r_cnt;
    assign o_expired = i_enable && (r_cnt == CW'(TIMEOUT_CYC - 1));
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_cnt <= '0;
        else if (i_clear) r_cnt <= '0;
        else if (i_enable && !o_expired) r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: rtl/wb_burst_master.sv
// wb_burst_master: Wishbone classic burst initiator, one GAP cycle between beats.
// Define WB_MASTER_TIMEOUT_EN to abort a beat after TIMEOUT_CYC cycles without ack/err.
module wb_burst_master import wb_master_pkg::*; #(
    parameter int LEN_W       = 8,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_we_i,
    input  logic [31:0]      cmd_adr_i,
    input  logic [3:0]       cmd_sel_i,
    input  logic [LEN_W-1:0] cmd_len_i,
    input  logic             wdat_valid_i,
    output logic             wdat_ready_o,
    input  logic [31:0]      wdat_i,
    output logic             rsp_valid_o,
    output logic [31:0]      rsp_dat_o,
    output logic             rsp_err_o,
    output logic             rsp_last_o,
    output logic             wb_cyc_o,
    output logic             wb_stb_o,
    output logic             wb_we_o,
    output logic [3:0]       wb_sel_o,
    output logic [31:0]      wb_adr_o,
    output logic [31:0]      wb_dat_o,
    input  logic [31:0]      wb_dat_i,
    input  logic             wb_ack_i,
    input  logic             wb_err_i
);
    state_t           r_state, w_next;
    logic             r_we, r_rsp_valid, r_rsp_err, r_rsp_last;
    logic [31:0]      r_adr, r_dat, r_rsp_dat;
    logic [3:0]       r_sel;
    logic [LEN_W-1:0] r_cnt;
    logic             w_accept, w_take, w_timeout, w_err, w_term, w_last, w_unused_adr;

    assign w_unused_adr = ^cmd_adr_i[1:0];
    assign w_accept = (r_state == ST_IDLE) && cmd_valid_i;
    assign w_take   = (r_state == ST_WDAT) && wdat_valid_i;

`ifdef WB_MASTER_TIMEOUT_EN
    wb_beat_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .i_clk    (wb_clk_i),
        .i_rst_n  (wb_rst_n_i),
        .i_clear  (r_state != ST_REQ),
        .i_enable (r_state == ST_REQ),
        .o_expired(w_timeout)
    );
`else
    localparam int unused_timeout = TIMEOUT_CYC;
    assign w_timeout = 1'b0;
`endif

    // ack and err together still count as an error
    assign w_err  = wb_err_i || w_timeout;
    assign w_term = (r_state == ST_REQ) && (wb_ack_i || w_err);
    assign w_last = w_err || (r_cnt == '0);

    assign cmd_ready_o  = r_state == ST_IDLE;
    assign wdat_ready_o = r_state == ST_WDAT;
    assign wb_cyc_o     = r_state != ST_IDLE;
    assign wb_stb_o     = r_state == ST_REQ;
    assign wb_we_o      = r_we;
    assign wb_sel_o     = r_sel;
    assign wb_adr_o     = r_adr;
    assign wb_dat_o     = r_dat;
    assign rsp_valid_o  = r_rsp_valid;
    assign rsp_dat_o    = r_rsp_dat;
    assign rsp_err_o    = r_rsp_err;
    assign rsp_last_o   = r_rsp_last;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) r_state <= ST_IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: w_next = cmd_valid_i ? (cmd_we_i ? ST_WDAT : ST_REQ) : ST_IDLE;
            ST_WDAT: w_next = wdat_valid_i ? ST_REQ : ST_WDAT;
            ST_REQ:  w_next = w_term ? (w_last ? ST_IDLE : ST_GAP) : ST_REQ;
            ST_GAP:  w_next = r_we ? ST_WDAT : ST_REQ;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_we        <= 1'b0;
            r_adr       <= '0;
            r_sel       <= '0;
            r_cnt       <= '0;
            r_dat       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_last  <= 1'b0;
            r_rsp_dat   <= '0;
        end else begin
            r_rsp_valid <= w_term;
            r_rsp_err   <= w_term && w_err;
            r_rsp_last  <= w_term && w_last;
            r_rsp_dat   <= (w_term && !r_we) ? wb_dat_i : '0;
            if (w_accept) begin
                r_we  <= cmd_we_i;
                r_adr <= {cmd_adr_i[31:2], 2'b00};
                r_sel <= cmd_sel_i;
                r_cnt <= cmd_len_i;
            end
            if (w_take) r_dat <= wdat_i;
            if (w_term && !w_last) begin
                r_cnt <= r_cnt - 1'b1;
                r_adr <= r_adr + ADR_INC;
            end
        end
    end
endmodule

// File: tb/tb_wb_burst_master.sv
// tb_wb_burst_master: directed burst vectors against a one-wait-state Wishbone RAM model.
module tb_wb_burst_master;
    logic        clk = 0, rst_n = 0;
    logic        cmd_valid = 0, cmd_we = 0, cmd_ready;
    logic [31:0] cmd_adr = 0;
    logic [3:0]  cmd_sel = 0;
    logic [7:0]  cmd_len = 0;
    logic        wdat_valid = 0, wdat_ready;
    logic [31:0] wdat = 0;
    logic        rsp_valid, rsp_err, rsp_last;
    logic [31:0] rsp_dat;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_o;
    logic [31:0] dat_i = 0;
    logic        ack = 0, err = 0;

    always #5 clk = ~clk;

    wb_burst_master #(.LEN_W(8), .TIMEOUT_CYC(16)) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
        .cmd_adr_i(cmd_adr), .cmd_sel_i(cmd_sel), .cmd_len_i(cmd_len),
        .wdat_valid_i(wdat_valid), .wdat_ready_o(wdat_ready), .wdat_i(wdat),
        .rsp_valid_o(rsp_valid), .rsp_dat_o(rsp_dat), .rsp_err_o(rsp_err), .rsp_last_o(rsp_last),
        .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we), .wb_sel_o(sel),
        .wb_adr_o(adr), .wb_dat_o(dat_o),
        .wb_dat_i(dat_i), .wb_ack_i(ack), .wb_err_i(err)
    );

    logic [31:0] mem [256];
    logic        resp_en = 1;
    int          err_at = 0, beat_n = 0;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        for (int b = 0; b < 4; b++) if (s[b]) o[8*b +: 8] = n[8*b +: 8];
        return o;
    endfunction

    // RAM responder: ack (or err on beat err_at) one cycle after stb rises
    always @(posedge clk) begin
        if (cmd_valid && cmd_ready) beat_n <= 0;
        if (cyc && stb && !ack && !err && resp_en) begin
            beat_n <= beat_n + 1;
            if (beat_n + 1 == err_at) begin
                err   <= 1;
                dat_i <= 32'hEEEE_EEEE;
            end else begin
                ack <= 1;
                if (we) mem[adr[9:2]] <= merge(mem[adr[9:2]], dat_o, sel);
                else dat_i <= mem[adr[9:2]];
            end
        end else begin
            ack <= 0;
            err <= 0;
        end
    end

    logic [31:0] q_dat[$], q_adr[$];
    logic        q_err[$], q_last[$];
    int          q_cyc[$];
    int          cyc_n = 0;
    logic        prev_stb = 0;
    int          n_cmp = 0, n_bad = 0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(negedge clk) begin
        if (rsp_valid) begin
            q_dat.push_back(rsp_dat);
            q_err.push_back(rsp_err);
            q_last.push_back(rsp_last);
            q_cyc.push_back(cyc_n);
        end
        if (stb && !prev_stb) q_adr.push_back(adr);
        prev_stb = stb;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic clear_q();
        q_dat.delete(); q_adr.delete(); q_err.delete(); q_last.delete(); q_cyc.delete();
    endtask

    task automatic run_burst(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [7:0] l,
                             input logic [31:0] wd0, input logic [31:0] wd1, input int dly, input int ea,
                             output int stb_wait, output int cyc_drop);
        int  idx = 0, waited = 0;
        bit  done = 0;
        err_at = ea;
        stb_wait = 0;
        cyc_drop = 0;
        clear_q();
        @(negedge clk);
        cmd_valid = 1; cmd_we = w; cmd_adr = a; cmd_sel = s; cmd_len = l;
        @(negedge clk);
        cmd_valid = 0;
        for (int c = 0; c < 2000 && !done; c++) begin
            if (rsp_valid && rsp_last) done = 1;
            else begin
                if (!cyc) cyc_drop++;
                if (wdat_ready && stb) stb_wait++;
                if (wdat_valid) begin
                    wdat_valid = 0;
                    idx++;
                    waited = 0;
                end else if (wdat_ready) begin
                    if (waited >= dly) begin
                        wdat_valid = 1;
                        wdat = (idx == 0) ? wd0 : wd1;
                    end else waited++;
                end
                @(negedge clk);
            end
        end
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL burst_done: got no last rsp expected one within 2000 cycles");
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [7:0]  len;
        logic [31:0] wd0, wd1;
        int          dly, err_at, n_rsp;
        logic [31:0] dat;
        logic        err;
        logic [31:0] adr_last;
    } vec_t;

    vec_t v[10];

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish by 500us");
        $fatal(1);
    end

    initial begin
        int sw, cd, nl, nstb;
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 | i;
        mem[0]  = 32'h0BAD_BEEF;
        mem[8]  = 32'hAABB_CCDD;
        mem[64] = 32'h0000_00A0; mem[65] = 32'h0000_00A1;
        mem[66] = 32'h0000_00A2; mem[67] = 32'h0000_00A3;
        mem[255] = 32'hFEED_F00D;

        //       we  adr           sel   len    wd0           wd1           dly err n   dat           err adr_last
        v[0] = '{0, 32'h100,      4'hF, 8'd3,   0,            0,            0, 0, 4,   32'hA3,       0, 32'h10C};
        v[1] = '{1, 32'h20,       4'h2, 8'd0,   32'h11223344, 0,            0, 0, 1,   32'h0,        0, 32'h20};
        v[2] = '{0, 32'h20,       4'hF, 8'd0,   0,            0,            0, 0, 1,   32'hAABB33DD, 0, 32'h20};
        v[3] = '{0, 32'h100,      4'hF, 8'd3,   0,            0,            0, 2, 2,   32'hEEEEEEEE, 1, 32'h104};
        v[4] = '{0, 32'hFFFFFFFC, 4'hF, 8'd1,   0,            0,            0, 0, 2,   32'h0BADBEEF, 0, 32'h0};
        v[5] = '{1, 32'h40,       4'hF, 8'd1,   32'h12345678, 32'h9ABCDEF0, 5, 0, 2,   32'h0,        0, 32'h44};
        v[6] = '{0, 32'h40,       4'hF, 8'd1,   0,            0,            0, 0, 2,   32'h9ABCDEF0, 0, 32'h44};
        v[7] = '{0, 32'h103,      4'hF, 8'd0,   0,            0,            0, 0, 1,   32'hA0,       0, 32'h100};
        v[8] = '{0, 32'h0,        4'hF, 8'd255, 0,            0,            0, 0, 256, 32'hFEEDF00D, 0, 32'h3FC};
        v[9] = '{1, 32'h80,       4'hF, 8'd1,   32'h55555555, 0,            0, 1, 1,   32'h0,        1, 32'h80};

        @(posedge clk); #1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_cyc_stb", {cyc, stb, we, wdat_ready}, 0);
        chk("rst_rsp", {rsp_valid, rsp_err, rsp_last}, 0);
        chk("rst_adr", adr, 0);
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 10; i++) begin
            run_burst(v[i].we, v[i].adr, v[i].sel, v[i].len, v[i].wd0, v[i].wd1, v[i].dly, v[i].err_at, sw, cd);
            nl = 0;
            foreach (q_last[k]) if (q_last[k]) nl++;
            chk($sformatf("v%0d n_rsp", i), q_dat.size(), v[i].n_rsp);
            chk($sformatf("v%0d n_stb", i), q_adr.size(), v[i].n_rsp);
            chk($sformatf("v%0d last_dat", i), q_dat.size() > 0 ? q_dat[q_dat.size()-1] : 32'hDEADDEAD, v[i].dat);
            chk($sformatf("v%0d last_err", i), q_err.size() > 0 ? q_err[q_err.size()-1] : 1'bx, v[i].err);
            chk($sformatf("v%0d n_last", i), nl, 1);
            chk($sformatf("v%0d last_adr", i), q_adr.size() > 0 ? q_adr[q_adr.size()-1] : 32'hDEADDEAD, v[i].adr_last);
            chk($sformatf("v%0d cyc_drop", i), cd, 0);
            chk($sformatf("v%0d stb_in_wdat", i), sw, 0);
        end
        chk("mem_0x40", mem[16], 32'h12345678);
        chk("mem_0x80_untouched", mem[32], 32'h1000_0020);

        run_burst(0, 32'h100, 4'hF, 8'd3, 0, 0, 0, 0, sw, cd);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rd_beat%0d_dat", k), q_dat.size() > k ? q_dat[k] : 32'hDEADDEAD, 32'hA0 + k);
            chk($sformatf("rd_beat%0d_last", k), q_last.size() > k ? q_last[k] : 1'bx, k == 3);
            chk($sformatf("rd_beat%0d_adr", k), q_adr.size() > k ? q_adr[k] : 32'hDEADDEAD, 32'h100 + 4 * k);
        end
        chk("rd_beat_period", q_cyc.size() > 1 ? q_cyc[1] - q_cyc[0] : 0, 3);

        clear_q();
        @(negedge clk);
        wdat_valid = 1; wdat = 32'hBAD0_BAD0;
        repeat (3) @(negedge clk);
        chk("idle_wdat_ignored", {cmd_ready, cyc, wdat_ready}, 3'b100);
        wdat_valid = 0;
        @(negedge clk);
        chk("idle_wdat_no_rsp", q_dat.size(), 0);

        resp_en = 0;
        clear_q();
        @(negedge clk);
        cmd_valid = 1; cmd_we = 0; cmd_adr = 32'h100; cmd_len = 8'd3;
        @(negedge clk);
        cmd_valid = 0;
        repeat (2) @(negedge clk);
        chk("pre_rst_stb", stb, 1);
        rst_n = 0;
        #1;
        chk("mid_rst_cmd_ready", cmd_ready, 1);
        chk("mid_rst_bus", {cyc, stb, we, sel, wdat_ready}, 0);
        chk("mid_rst_adr", adr, 0);
        chk("mid_rst_rsp", {rsp_valid, rsp_err, rsp_last}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        resp_en = 1;
        repeat (5) @(negedge clk);
        chk("mid_rst_no_rsp", q_dat.size(), 0);
        run_burst(0, 32'h104, 4'hF, 8'd0, 0, 0, 0, 0, sw, cd);
        chk("post_rst_dat", q_dat.size() > 0 ? q_dat[0] : 32'hDEADDEAD, 32'hA1);

`ifdef WB_MASTER_TIMEOUT_EN
        resp_en = 0;
        @(negedge clk);
        cmd_valid = 1; cmd_we = 0; cmd_adr = 32'h100; cmd_len = 8'd3;
        @(negedge clk);
        cmd_valid = 0;
        nstb = 0;
        for (int c = 0; c < 100 && !rsp_valid; c++) begin
            if (stb) nstb++;
            @(negedge clk);
        end
        chk("tmo_stb_cycles", nstb, 16);
        chk("tmo_rsp", {rsp_valid, rsp_err, rsp_last}, 3'b111);
        chk("tmo_idle", {cyc, stb, cmd_ready}, 3'b001);
        resp_en = 1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
